// File: rtl/aes_host_ctrl.sv
// Byte-stream host front end for an AES core. It collects a command, an optional key and
// the text block, launches the core, waits for a result (with a timeout) and streams it back.
module aes_host_ctrl #(
  parameter int TIMEOUT = 1023
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [7:0]   i_Byte,
  input  logic         i_fByteVld,
  output logic         o_fByteRdy,
  output logic [7:0]   o_Byte,
  output logic         o_fOutVld,
  input  logic         i_fOutRdy,
  output logic [127:0] o_Key,
  output logic [127:0] o_Text,
  output logic         o_fEnc,
  output logic         o_fStart,
  input  logic [127:0] i_Data,
  input  logic         i_fDone,
  output logic         o_fBusy,
  output logic         o_fErr
);

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_TEXT, S_START, S_WAIT, S_SEND} state_t;

  // The START cycle counts as the first waited cycle, so the error lands TIMEOUT cycles after o_fStart.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t        state_q;
  logic [127:0]  key_q, text_q, sh_q;
  logic [127:0]  key_d, text_d, sh_d;
  logic [3:0]    bcnt_q;
  logic [15:0]   wcnt_q;
  logic          enc_q, start_q, vld_q, err_q, keyvld_q;
  logic          byte_xfer;

  assign o_fByteRdy = (state_q == S_IDLE) || (state_q == S_KEY) || (state_q == S_TEXT);
  assign o_fBusy    = (state_q != S_IDLE);
  assign byte_xfer  = i_fByteVld && o_fByteRdy;

  assign key_d  = {key_q[119:0], i_Byte};
  assign text_d = {text_q[119:0], i_Byte};
  assign sh_d   = {sh_q[119:0], 8'h00};

  assign o_Key     = key_q;
  assign o_Text    = text_q;
  assign o_Byte    = sh_q[127:120];
  assign o_fOutVld = vld_q;
  assign o_fEnc    = enc_q;
  assign o_fStart  = start_q;
  assign o_fErr    = err_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      text_q   <= '0;
      sh_q     <= '0;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
      enc_q    <= 1'b0;
      start_q  <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      keyvld_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (byte_xfer) begin
            if (i_Byte[7:2] != 6'd0) begin
              err_q <= 1'b1;
            end else begin
              enc_q   <= i_Byte[0];
              bcnt_q  <= 4'd0;
              state_q <= (i_Byte[1] && keyvld_q) ? S_TEXT : S_KEY;
            end
          end
        end
        S_KEY: begin
          if (byte_xfer) begin
            key_q  <= key_d;
            bcnt_q <= bcnt_q + 4'd1;
            if (bcnt_q == 4'd15) begin
              keyvld_q <= 1'b1;
              state_q  <= S_TEXT;
            end
          end
        end
        S_TEXT: begin
          if (byte_xfer) begin
            text_q <= text_d;
            bcnt_q <= bcnt_q + 4'd1;
            if (bcnt_q == 4'd15) begin
              start_q <= 1'b1;
              state_q <= S_START;
            end
          end
        end
        S_START: begin
          wcnt_q  <= 16'd1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_fDone) begin
            sh_q    <= i_Data;
            vld_q   <= 1'b1;
            bcnt_q  <= 4'd0;
            state_q <= S_SEND;
          end else if (wcnt_q >= WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wcnt_q <= wcnt_q + 16'd1;
          end
        end
        S_SEND: begin
          if (i_fOutRdy) begin
            sh_q   <= sh_d;
            bcnt_q <= bcnt_q + 4'd1;
            if (bcnt_q == 4'd15) begin
              vld_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Bench for aes_host_ctrl: scenario tasks drive byte frames and a behavioural AES-core model,
// comparing against a key/frame reference kept here. A second instance runs with TIMEOUT=8.
`timescale 1ns/1ps
module tb_aes_host_ctrl;

  localparam int TO2 = 8;

  logic         i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic         i_Rst, t_Rst;
  logic [7:0]   i_Byte;
  logic         i_fByteVld, o_fByteRdy;
  logic [7:0]   o_Byte;
  logic         o_fOutVld, i_fOutRdy;
  logic [127:0] o_Key, o_Text, i_Data;
  logic         o_fEnc, o_fStart, i_fDone, o_fBusy, o_fErr;

  logic         t_fByteRdy, t_fOutVld, t_fOutRdy, t_fEnc, t_fStart, t_fDone, t_fBusy, t_fErr;
  logic [7:0]   t_Byte;
  logic [127:0] t_Key, t_Text;

  int           errors = 0;
  int           checks = 0;
  logic [127:0] m_key;
  bit           m_keyvld;

  aes_host_ctrl dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Byte(i_Byte), .i_fByteVld(i_fByteVld),
    .o_fByteRdy(o_fByteRdy), .o_Byte(o_Byte), .o_fOutVld(o_fOutVld), .i_fOutRdy(i_fOutRdy),
    .o_Key(o_Key), .o_Text(o_Text), .o_fEnc(o_fEnc), .o_fStart(o_fStart),
    .i_Data(i_Data), .i_fDone(i_fDone), .o_fBusy(o_fBusy), .o_fErr(o_fErr)
  );

  aes_host_ctrl #(.TIMEOUT(TO2)) dut_to (
    .i_Clk(i_Clk), .i_Rst(t_Rst), .i_Byte(i_Byte), .i_fByteVld(i_fByteVld),
    .o_fByteRdy(t_fByteRdy), .o_Byte(t_Byte), .o_fOutVld(t_fOutVld), .i_fOutRdy(t_fOutRdy),
    .o_Key(t_Key), .o_Text(t_Text), .o_fEnc(t_fEnc), .o_fStart(t_fStart),
    .i_Data(i_Data), .i_fDone(t_fDone), .o_fBusy(t_fBusy), .o_fErr(t_fErr)
  );

  // Presents one byte from a falling edge and holds it until the selected instance takes it.
  task automatic send_byte(input logic [7:0] b, input bit sel);
    bit ok;
    logic rdy;
    ok = 1'b0;
    @(negedge i_Clk);
    i_Byte = b;
    i_fByteVld = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rdy = sel ? t_fByteRdy : o_fByteRdy;
      if (rdy === 1'b1) begin
        @(posedge i_Clk);
        ok = 1'b1;
        break;
      end
      @(negedge i_Clk);
    end
    #1 i_fByteVld = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept: byte %02h ready=%b after 40 cycles, required ready=1", b, rdy);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [127:0] key, input logic [127:0] text,
                           input logic [127:0] data, input int delay, input int stall_n, input bit noise);
    bit reuse;
    logic [127:0] exp_key;
    int idx, n;
    reuse   = cmd[1] && m_keyvld;
    exp_key = reuse ? m_key : key;
    i_fDone = noise;
    i_Data  = {$urandom, $urandom, $urandom, $urandom};
    send_byte(cmd, 1'b0);
    @(negedge i_Clk);
    checks++;
    if (o_fBusy !== 1'b1 || o_fErr !== 1'b0) begin
      errors++;
      $display("FAIL cmd_accept: busy=%b err=%b, required busy=1 err=0", o_fBusy, o_fErr);
    end
    if (!reuse) begin
      for (int i = 0; i < 16; i++) send_byte(key[127-8*i -: 8], 1'b0);
      m_key = key;
      m_keyvld = 1'b1;
    end
    for (int i = 0; i < 16; i++) send_byte(text[127-8*i -: 8], 1'b0);
    i_fDone = 1'b0;
    @(negedge i_Clk);
    checks++;
    if (o_fStart !== 1'b1 || o_Key !== exp_key || o_Text !== text || o_fEnc !== cmd[0] ||
        o_fByteRdy !== 1'b0 || o_fOutVld !== 1'b0) begin
      errors++;
      $display("FAIL start_cycle: start=%b key=%h text=%h enc=%b rdy=%b vld=%b, required 1 %h %h %b 0 0",
               o_fStart, o_Key, o_Text, o_fEnc, o_fByteRdy, o_fOutVld, exp_key, text, cmd[0]);
    end
    for (int k = 1; k <= delay; k++) begin
      @(negedge i_Clk);
      checks++;
      if (o_fStart !== 1'b0 || o_fOutVld !== 1'b0 || o_fBusy !== 1'b1 || o_fByteRdy !== 1'b0) begin
        errors++;
        $display("FAIL wait_phase: cycle %0d start=%b vld=%b busy=%b rdy=%b, required 0 0 1 0",
                 k, o_fStart, o_fOutVld, o_fBusy, o_fByteRdy);
      end
      if (k == delay) begin
        i_fDone = 1'b1;
        i_Data  = data;
      end
    end
    @(negedge i_Clk);
    i_fDone = 1'b0;
    i_Data  = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if (o_fOutVld !== 1'b1) begin
      errors++;
      $display("FAIL outvld_rise: vld=%b one cycle after done, required 1", o_fOutVld);
    end
    idx = 0;
    n = 0;
    while (idx < 16 && n < 300) begin
      checks++;
      if (o_fOutVld !== 1'b1 || o_Byte !== data[127-8*idx -: 8]) begin
        errors++;
        $display("FAIL out_byte: idx %0d vld=%b byte=%02h, required vld=1 byte=%02h",
                 idx, o_fOutVld, o_Byte, data[127-8*idx -: 8]);
      end
      i_fOutRdy = (n < stall_n) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (i_fOutRdy) idx++;
      @(negedge i_Clk);
      n++;
    end
    i_fOutRdy = 1'b0;
    checks++;
    if (idx != 16 || o_fOutVld !== 1'b0 || o_fBusy !== 1'b0 || o_fByteRdy !== 1'b1) begin
      errors++;
      $display("FAIL frame_end: bytes=%0d vld=%b busy=%b rdy=%b, required 16 0 0 1",
               idx, o_fOutVld, o_fBusy, o_fByteRdy);
    end
  endtask

  task automatic test_reset;
    @(negedge i_Clk);
    i_Rst = 1'b1;
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    m_keyvld = 1'b0;
    checks++;
    if (o_fByteRdy !== 1'b1 || o_fBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%b busy=%b, required rdy=1 busy=0", o_fByteRdy, o_fBusy);
    end
    checks++;
    if (o_Key !== '0 || o_Text !== '0 || o_Byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: key=%h text=%h byte=%02h, required all zero", o_Key, o_Text, o_Byte);
    end
    checks++;
    if (o_fEnc !== 1'b0 || o_fStart !== 1'b0 || o_fOutVld !== 1'b0 || o_fErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: enc=%b start=%b vld=%b err=%b, required all 0",
               o_fEnc, o_fStart, o_fOutVld, o_fErr);
    end
  endtask

  task automatic test_basic;
    run_frame(8'h01, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20, 0, 1'b0);
  endtask

  task automatic test_key_reuse;
    run_frame(8'h02, {4{$urandom}}, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 12, 0, 1'b1);
    test_reset;
    run_frame(8'h02, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 5, 0, 1'b0);
  endtask

  task automatic test_bad_cmd;
    logic [7:0] c;
    for (int i = 0; i < 4; i++) begin
      c = (i == 0) ? 8'h80 : {6'($urandom_range(1, 63)), 2'($urandom_range(0, 3))};
      send_byte(c, 1'b0);
      @(negedge i_Clk);
      checks++;
      if (o_fErr !== 1'b1 || o_fBusy !== 1'b0 || o_fByteRdy !== 1'b1) begin
        errors++;
        $display("FAIL bad_cmd: cmd %02h err=%b busy=%b rdy=%b, required 1 0 1", c, o_fErr, o_fBusy, o_fByteRdy);
      end
      @(negedge i_Clk);
      checks++;
      if (o_fErr !== 1'b0 || o_fBusy !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse: cmd %02h err=%b busy=%b next cycle, required 0 0", c, o_fErr, o_fBusy);
      end
    end
    run_frame(8'h03, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 3, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int f = 0; f < 8; f++) begin
      run_frame({6'd0, 2'($urandom_range(0, 3))},
                {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 60),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_stall_and_reset;
    run_frame(8'h01, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 7, 5, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
    test_reset;
    run_frame(8'h03, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 9, 2, 1'b0);
  endtask

  task automatic test_timeout;
    logic [127:0] d2;
    d2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge i_Clk);
    i_Rst = 1'b1;
    t_Rst = 1'b1;
    @(negedge i_Clk);
    t_Rst = 1'b0;
    send_byte(8'h01, 1'b1);
    for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b1);
    @(negedge i_Clk);
    checks++;
    if (t_fStart !== 1'b1) begin
      errors++;
      $display("FAIL to_start: start=%b, required 1", t_fStart);
    end
    for (int k = 1; k < TO2; k++) begin
      @(negedge i_Clk);
      checks++;
      if (t_fErr !== 1'b0 || t_fBusy !== 1'b1) begin
        errors++;
        $display("FAIL to_wait: cycle %0d err=%b busy=%b, required 0 1", k, t_fErr, t_fBusy);
      end
    end
    @(negedge i_Clk);
    checks++;
    if (t_fErr !== 1'b1 || t_fBusy !== 1'b0 || t_fByteRdy !== 1'b1) begin
      errors++;
      $display("FAIL to_expire: err=%b busy=%b rdy=%b %0d cycles after start, required 1 0 1",
               t_fErr, t_fBusy, t_fByteRdy, TO2);
    end
    @(negedge i_Clk);
    checks++;
    if (t_fErr !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: err=%b next cycle, required 0", t_fErr);
    end
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    @(negedge i_Clk);
    checks++;
    if (t_fStart !== 1'b1 || t_fEnc !== 1'b1) begin
      errors++;
      $display("FAIL to_reuse_start: start=%b enc=%b, required 1 1", t_fStart, t_fEnc);
    end
    for (int k = 1; k < TO2; k++) begin
      @(negedge i_Clk);
      if (k == TO2 - 1) begin
        t_fDone = 1'b1;
        i_Data  = d2;
      end
    end
    @(negedge i_Clk);
    t_fDone = 1'b0;
    checks++;
    if (t_fOutVld !== 1'b1 || t_fErr !== 1'b0 || t_Byte !== d2[127:120]) begin
      errors++;
      $display("FAIL done_at_expiry: vld=%b err=%b byte=%02h, required 1 0 %02h",
               t_fOutVld, t_fErr, t_Byte, d2[127:120]);
    end
    t_fOutRdy = 1'b1;
    repeat (16) @(negedge i_Clk);
    t_fOutRdy = 1'b0;
    checks++;
    if (t_fOutVld !== 1'b0 || t_fBusy !== 1'b0) begin
      errors++;
      $display("FAIL to_drain: vld=%b busy=%b, required 0 0", t_fOutVld, t_fBusy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    i_Rst = 1'b1;
    t_Rst = 1'b1;
    i_Byte = 8'h00;
    i_fByteVld = 1'b0;
    i_fOutRdy = 1'b0;
    i_Data = '0;
    i_fDone = 1'b0;
    t_fDone = 1'b0;
    t_fOutRdy = 1'b0;
    m_key = '0;
    m_keyvld = 1'b0;
    repeat (2) @(negedge i_Clk);
    test_reset;
    test_basic;
    test_key_reuse;
    test_bad_cmd;
    test_random;
    test_stall_and_reset;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_host_ctrl.md
AES_HOST_CTRL -- requirements
Module: aes_host_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: cycles to wait for i_fDone after o_fStart before aborting (range 1..65535).
REQ-002 SHALL have port i_Clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port i_Rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports i_Byte (input, 8), i_fByteVld (input, 1), o_fByteRdy (output, 1): inbound command/key/text byte stream; a transfer occurs when valid and ready are both high.
REQ-005 SHALL have ports o_Byte (output, 8), o_fOutVld (output, 1), i_fOutRdy (input, 1): outbound result byte stream, same handshake rule.
REQ-006 SHALL have ports o_Key (output, 128), o_Text (output, 128), o_fEnc (output, 1), o_fStart (output, 1): request side toward the AES core.
REQ-007 SHALL have ports i_Data (input, 128), i_fDone (input, 1): result side from the AES core.
REQ-008 SHALL have ports o_fBusy (output, 1) and o_fErr (output, 1): busy whenever not IDLE; error is a one-cycle pulse.

Function
REQ-009 SHALL implement states IDLE, KEY, TEXT, START, WAIT, SEND.
REQ-010 IDLE SHALL assert o_fByteRdy; the accepted byte is a command: bit0 = enc(1)/dec(0), bit1 = reuse stored key, bits[7:2] reserved.
REQ-011 A command with any reserved bit set SHALL be discarded, pulse o_fErr for one cycle and remain in IDLE.
REQ-012 A valid command SHALL latch bit0 into o_fEnc and go to TEXT if bit1=1 and the key-valid flag is set, otherwise to KEY.
REQ-013 KEY SHALL accept exactly 16 bytes into o_Key, first byte into [127:120] and last into [7:0], then set the key-valid flag and go to TEXT.
REQ-014 TEXT SHALL accept exactly 16 bytes into o_Text with the same byte order, then go to START.
REQ-015 START SHALL hold o_fStart high for exactly one cycle, the cycle after the 16th text byte is accepted, then go to WAIT.
REQ-016 o_fByteRdy SHALL be low in START, WAIT and SEND.
REQ-017 o_Key and o_Text SHALL stay stable from START until the next byte is loaded into them.
REQ-018 WAIT SHALL count cycles; on i_fDone it SHALL capture i_Data into the output shift register and go to SEND.
REQ-019 If TIMEOUT cycles elapse in WAIT without i_fDone, the block SHALL pulse o_fErr and go to IDLE; i_fDone in the same cycle as expiry takes priority.
REQ-020 i_fDone outside WAIT SHALL be ignored.
REQ-021 SEND SHALL drive o_fOutVld=1 and o_Byte = result[127:120] first; each accepted byte shifts the next byte out.
REQ-022 After the 16th output byte is accepted, the block SHALL return to IDLE; o_Byte SHALL hold stable while i_fOutRdy is low.
REQ-023 Byte counters SHALL be 4-bit and wrap 15->0 exactly at each phase end.
REQ-024 o_fOutVld SHALL rise in the cycle after i_fDone is captured.

Reset
REQ-025 i_Rst high at a clock edge SHALL force IDLE from any state, including mid-phase.
REQ-026 Reset SHALL set o_Key, o_Text, the shift register and o_Byte to 0, set o_fEnc, o_fStart, o_fOutVld, o_fErr and o_fBusy to 0, and clear the key-valid flag and all counters.
REQ-027 o_fByteRdy SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-028 Cmd 0x01, key bytes 00..0f, text 00112233445566778899aabbccddeeff, model asserts i_fDone 20 cycles after start with 69c4e0d86a7b0430d8cdb78070b4c55a -> o_Key/o_Text match, single o_fStart, o_fEnc=1, output bytes 69,c4,...,5a, then IDLE.
REQ-029 After REQ-028, cmd 0x02 plus 16 text bytes -> no key bytes consumed, o_Key unchanged, o_fEnc=0; after a fresh reset, cmd 0x02 -> goes to KEY.
REQ-030 Cmd 0x80 -> o_fErr high for one cycle, o_fBusy stays 0, next byte is again treated as a command.
REQ-031 TIMEOUT=8 with the model never asserting i_fDone -> o_fErr pulse 8 cycles after o_fStart, then IDLE with o_fByteRdy=1.
REQ-032 i_fOutRdy held low for 5 cycles during SEND -> o_Byte and o_fOutVld stable; reset after 7 text bytes -> IDLE, outputs zeroed, next full frame completes correctly.
